// File: rtl/aes128_package.sv
`default_nettype none
// ============================================================================
// Module   : aes128_package
// Brief    : Shared GF(2^2)/GF(2^4) nibble types for the tower-field datapath
// Revision : 1.0
// ============================================================================
package aes128_package;

    typedef logic [1:0] bv2_t;
    typedef logic [3:0] bv4_t;

    // Register stages between in_a and out_b of the sq_scl_s inverse pipeline
    localparam int BV4_SQ_SCL_S_INV_LATENCY = 2;

endpackage
`default_nettype wire

// File: rtl/bv2_scl_sigma2.sv
`default_nettype none
// ============================================================================
// Module   : bv2_scl_sigma2
// Brief    : GF(4) multiply by Sigma^2 = w^2 = w + 1 (an element of order 3)
// Revision : 1.0
// ============================================================================
module bv2_scl_sigma2
    import aes128_package::*;
(
    input  bv2_t in_a,
    output bv2_t out_b
);

    assign out_b = {in_a[0], in_a[1] ^ in_a[0]};

endmodule
`default_nettype wire

// File: rtl/bv2_sq.sv
`default_nettype none
// ============================================================================
// Module   : bv2_sq
// Brief    : GF(4) squaring (also its own inverse, i.e. the square root)
// Revision : 1.0
// ============================================================================
module bv2_sq
    import aes128_package::*;
(
    input  bv2_t in_a,
    output bv2_t out_b
);

    // Basis {w, 1} with w^2 = w + 1: (a1 w + a0)^2 = a1 w + (a1 + a0)
    assign out_b = {in_a[1], in_a[1] ^ in_a[0]};

endmodule
`default_nettype wire

// File: rtl/bv4_unsq_scl_s_lo.sv
`default_nettype none
// ============================================================================
// Module   : bv4_unsq_scl_s_lo
// Brief    : First half of the sq_scl_s inverse; yields {p1, p0} = {x1^2, x0^2}
// Revision : 1.0
// ============================================================================
module bv4_unsq_scl_s_lo
    import aes128_package::*;
(
    input  bv4_t in_a,
    output bv4_t out_b
);

    bv2_t w_sig_once;
    bv2_t w_p0;

    // Sigma^2 has order 3, so applying it twice undoes one application
    bv2_scl_sigma2 u_sig_a (.in_a(in_a[1:0]), .out_b(w_sig_once));
    bv2_scl_sigma2 u_sig_b (.in_a(w_sig_once), .out_b(w_p0));

    assign out_b = {in_a[3:2] ^ w_p0, w_p0};

endmodule
`default_nettype wire

// File: rtl/bv4_sq_scl_s_inv_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bv4_sq_scl_s_inv_pipe
// Brief    : Two-stage valid/ready pipeline inverting sq_scl_s on N_LANES nibbles
// Revision : 1.0
// ============================================================================
module bv4_sq_scl_s_inv_pipe
    import aes128_package::*;
#(
    parameter int N_LANES = 4
) (
    input  logic                   in_clock,
    input  logic                   in_reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*N_LANES-1:0]   in_a,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*N_LANES-1:0]   out_b,
    output logic [15:0]            out_count
);

    typedef bv4_t [N_LANES-1:0] bv4_lanes_t;

    bv4_lanes_t r_s1_data;
    bv4_lanes_t r_s2_data;
    bv4_lanes_t w_s1_next;
    bv4_lanes_t w_s2_next;
    logic       r_s1_valid;
    logic       r_s2_valid;
    logic [15:0] r_out_count;
    logic       w_s2_load;
    logic       w_s1_load;

    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
        bv4_unsq_scl_s_lo u_lo (
            .in_a  (in_a[4*gi +: 4]),
            .out_b (w_s1_next[gi])
        );
        bv2_sq u_sq_lo (
            .in_a  (r_s1_data[gi][1:0]),
            .out_b (w_s2_next[gi][1:0])
        );
        bv2_sq u_sq_hi (
            .in_a  (r_s1_data[gi][3:2]),
            .out_b (w_s2_next[gi][3:2])
        );
    end

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = w_s2_load || !r_s1_valid;
    assign in_ready  = !in_reset && (!r_s1_valid || w_s2_load);

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s2_data   <= '0;
            r_out_count <= 16'h0000;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_s2_next;
                end
            end
            if (w_s1_load) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_data <= w_s1_next;
                end
            end
            if (r_s2_valid && out_ready) begin
                r_out_count <= r_out_count + 16'd1;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_b     = r_s2_data;
    assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_bv4_sq_scl_s_inv_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bv4_sq_scl_s_inv_pipe
// Brief    : Directed self-checking bench for bv4_sq_scl_s_inv_pipe
// Revision : 1.0
// ============================================================================
module tb_bv4_sq_scl_s_inv_pipe;
    import aes128_package::*;

    localparam int N_LANES = 4;

    logic                 clk = 1'b0;
    logic                 in_reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*N_LANES-1:0] in_a;
    logic                 out_valid;
    logic                 out_ready;
    logic [4*N_LANES-1:0] out_b;
    logic [15:0]          out_count;

    int checks = 0;
    int errors = 0;

    // y = sq_scl_s(x) for x = 0..15, worked out by hand
    logic [3:0] sq_tab [16];
    logic [3:0] rt_out [16];

    always #5 clk = ~clk;

    bv4_sq_scl_s_inv_pipe #(.N_LANES(N_LANES)) dut (
        .in_clock  (clk),
        .in_reset  (in_reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_count (out_count)
    );

    function automatic logic [1:0] gf4_sq(input logic [1:0] a);
        return {a[1], a[1] ^ a[0]};
    endfunction

    function automatic logic [1:0] gf4_sig2(input logic [1:0] a);
        return {a[0], a[1] ^ a[0]};
    endfunction

    // Forward map: y1 = x1^2 + x0^2, y0 = Sigma^2 * x0^2
    function automatic logic [3:0] fwd(input logic [3:0] x);
        return {gf4_sq(x[3:2]) ^ gf4_sq(x[1:0]), gf4_sig2(gf4_sq(x[1:0]))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_reset  = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        out_ready = 1'b1;
        tick();
        tick();
        in_reset  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        in_reset  = 1'b1;
        in_valid  = 1'b1;
        in_a      = 16'hFFFF;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_b !== 16'h0000) begin
            errors++; $display("FAIL reset_out_b: got %h expected 0000", out_b);
        end
        checks++;
        if (out_count !== 16'h0000) begin
            errors++; $display("FAIL reset_out_count: got %h expected 0000", out_count);
        end
        in_reset = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready_release: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_round_trip();
        logic [15:0] seen;
        logic [3:0]  exp_x;
        do_reset();
        for (int j = 0; j < 19; j++) begin
            checks++;
            if (j < BV4_SQ_SCL_S_INV_LATENCY) begin
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL rt_latency: slot %0d out_valid %b expected 0", j, out_valid);
                end
            end else begin
                exp_x = (j - 2 < 16) ? 4'(j - 2) : 4'h0;
                if (out_valid !== 1'b1 || out_b !== {12'h000, exp_x}) begin
                    errors++;
                    $display("FAIL rt_value: slot %0d got valid %b data %h expected valid 1 data %h",
                             j, out_valid, out_b, {12'h000, exp_x});
                end
                if (j - 2 < 16) rt_out[j-2] = out_b[3:0];
            end
            if (j < 17) begin
                in_valid = 1'b1;
                in_a     = (j < 16) ? {12'h000, sq_tab[j]} : 16'h0000;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        seen = '0;
        for (int k = 0; k < 16; k++) seen[rt_out[k]] = 1'b1;
        checks++;
        if (seen !== 16'hFFFF) begin
            errors++; $display("FAIL bij_distinct: got mask %h expected ffff", seen);
        end
    endtask

    task automatic test_bijectivity();
        logic [15:0] sent [16];
        logic [15:0] back;
        do_reset();
        for (int j = 0; j < 18; j++) begin
            if (j >= 2) begin
                back = {fwd(out_b[15:12]), fwd(out_b[11:8]), fwd(out_b[7:4]), fwd(out_b[3:0])};
                checks++;
                if (out_valid !== 1'b1 || back !== sent[j-2]) begin
                    errors++;
                    $display("FAIL bij_roundtrip: beat %0d got valid %b fwd(out_b) %h expected %h",
                             j - 2, out_valid, back, sent[j-2]);
                end
            end
            if (j < 16) begin
                sent[j] = {4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                           4'($urandom_range(15, 0)), sq_tab[j]};
                in_valid = 1'b1;
                in_a     = sent[j];
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int         n_in  = 0;
        int         n_out = 0;
        logic [3:0] ex;
        do_reset();
        for (int t = 0; t < 40 && n_out < 8; t++) begin
            out_ready = !(t >= 3 && t <= 6);
            #1;
            if (t == 3) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_in_ready_drop: got %b expected 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                ex = 4'(n_out * 5 + 3);
                checks++;
                if (out_b !== {8'h00, 4'(n_out), ex}) begin
                    errors++;
                    $display("FAIL bp_order: beat %0d got %h expected %h", n_out, out_b, {8'h00, 4'(n_out), ex});
                end
                n_out++;
            end
            if (n_in < 8) begin
                in_valid = 1'b1;
                in_a     = {8'h00, sq_tab[4'(n_in)], sq_tab[4'(n_in * 5 + 3)]};
                if (in_ready) n_in++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (n_out != 8) begin
            errors++; $display("FAIL bp_beats: got %0d beats expected 8", n_out);
        end
        checks++;
        if (out_count !== 16'd8) begin
            errors++; $display("FAIL bp_count: got %0d expected 8", out_count);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_dup: out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_a     = {12'h000, sq_tab[4'(k + 9)]};
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || out_count !== 16'd2) begin
            errors++; $display("FAIL rm_prefill: got valid %b count %0d expected 1 / 2", out_valid, out_count);
        end
        in_reset = 1'b1;
        in_a     = 16'hFFFF;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL rm_in_ready: got %b expected 0", in_ready);
        end
        tick();
        in_reset = 1'b0;
        in_a     = {12'h000, sq_tab[11]};
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_count !== 16'h0000 || out_b !== 16'h0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rm_after: got valid %b count %h data %h ready %b expected 0 0000 0000 1",
                     out_valid, out_count, out_b, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rm_latency: out_valid %b expected 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_b !== 16'h000B) begin
            errors++; $display("FAIL rm_next_beat: got valid %b data %h expected 1 000b", out_valid, out_b);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rm_drain: out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = {12'h000, sq_tab[1]};
        tick();
        in_a      = {12'h000, sq_tab[2]};
        tick();
        in_a      = {12'h000, sq_tab[15]};
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_b !== 16'h0001) begin
            errors++;
            $display("FAIL sim_full: got ready %b valid %b data %h expected 0 1 0001", in_ready, out_valid, out_b);
        end
        tick();
        out_ready = 1'b1;
        in_a      = {12'h000, sq_tab[3]};
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_b !== 16'h0001) begin
            errors++; $display("FAIL sim_ready: got ready %b data %h expected 1 0001", in_ready, out_b);
        end
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_b !== 16'h0002 || out_count !== 16'd1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL sim_shift: got valid %b data %h count %0d ready %b expected 1 0002 1 0",
                     out_valid, out_b, out_count, in_ready);
        end
        tick();
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_b !== 16'h0003 || out_count !== 16'd2) begin
            errors++;
            $display("FAIL sim_drain: got valid %b data %h count %0d expected 1 0003 2", out_valid, out_b, out_count);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_count !== 16'd3) begin
            errors++; $display("FAIL sim_end: got valid %b count %0d expected 0 3", out_valid, out_count);
        end
    endtask

    task automatic test_counter_wrap();
        int n = 0;
        do_reset();
        in_valid  = 1'b1;
        in_a      = 16'h0000;
        out_ready = 1'b1;
        for (int t = 0; t < 70000 && n < 65537; t++) begin
            if (out_valid) n++;
            tick();
            if (n == 65536 && out_valid) begin
                checks++;
                if (out_count !== 16'h0000) begin
                    errors++; $display("FAIL wrap_zero: got %h expected 0000", out_count);
                end
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        checks++;
        if (n != 65537) begin
            errors++; $display("FAIL wrap_beats: got %0d beats expected 65537", n);
        end
        checks++;
        if (out_count !== 16'h0001) begin
            errors++; $display("FAIL wrap_count: got %h expected 0001", out_count);
        end
    endtask

    initial begin
        sq_tab = '{4'h0, 4'h7, 4'hE, 4'h9, 4'h4, 4'h3, 4'hA, 4'hD,
                   4'hC, 4'hB, 4'h2, 4'h5, 4'h8, 4'hF, 4'h6, 4'h1};
        in_reset  = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        out_ready = 1'b1;
        #1;
        test_reset();
        test_round_trip();
        test_bijectivity();
        test_backpressure();
        test_reset_mid();
        test_simultaneous();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
